// File: rtl/redundant_to_fp.sv
// Converts one redundant L3 polynomial (value limbs plus carries) into a canonical
// BN254 field element: sequential carry resolution, then three conditional subtractions.
module redundant_to_fp #(
   parameter int           ADD_DIV  = 4,
   parameter int           L3_CARRY = 8,
   parameter int           LIMB_W   = 68,
   parameter int           FP_W     = 272,
   parameter logic [255:0] MOD      = 256'h2523648240000001ba344d80000000086121000000000013a700000000000013
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [ADD_DIV*(L3_CARRY+LIMB_W)-1:0]  in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [FP_W-1:0]                       out_data,
   output logic                                  out_ovf,
   output logic [1:0]                            dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, and out_data/out_ovf hold
   // stable while out_valid is high and out_ready is low.

   localparam int TERM_W = L3_CARRY + LIMB_W;
   localparam int IN_W   = ADD_DIV * TERM_W;
   localparam int S_W    = LIMB_W + 2;
   localparam int J_W    = $clog2(ADD_DIV);
   localparam logic [J_W-1:0] J_LAST = J_W'(ADD_DIV - 1);

   localparam logic [FP_W-1:0] K1 = FP_W'(MOD);
   localparam logic [FP_W-1:0] K2 = K1 << 1;
   localparam logic [FP_W-1:0] K4 = K1 << 2;
   localparam logic [FP_W-1:0] K8 = K1 << 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CARRY = 2'd1,
      S_RED   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [IN_W-1:0]     in_reg;
   logic [FP_W-1:0]     acc;
   logic [9:0]          cr;
   logic [J_W-1:0]      j;
   logic [1:0]          r;
   logic                ovf;

   logic [J_W-1:0]      jm1;
   logic [LIMB_W-1:0]   val_j;
   logic [L3_CARRY-1:0] carry_prev;
   logic [L3_CARRY-1:0] carry_last;
   logic [S_W-1:0]      s;
   logic [9:0]          cr_nxt;
   logic [9:0]          top;
   logic [FP_W-1:0]     k_sel;

   always_comb begin
      jm1        = j - 1'b1;
      val_j      = in_reg[j*TERM_W +: LIMB_W];
      carry_prev = (j == '0) ? '0 : in_reg[jm1*TERM_W + LIMB_W +: L3_CARRY];
      carry_last = in_reg[(ADD_DIV-1)*TERM_W + LIMB_W +: L3_CARRY];
      s          = S_W'(val_j) + S_W'(carry_prev) + S_W'(cr);
      cr_nxt     = 10'(s >> LIMB_W);
      // Anything left above the top limb means V >= 2^FP_W.
      top        = 10'(carry_last) + cr_nxt;
      case (r)
         2'd0:    k_sel = K4;
         2'd1:    k_sel = K2;
         default: k_sel = K1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid)       state_nxt = S_CARRY;
         S_CARRY: if (j == J_LAST)    state_nxt = S_RED;
         S_RED:   if (r == 2'd2)      state_nxt = S_DONE;
         S_DONE:  if (out_ready)      state_nxt = S_IDLE;
         default:                     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_reg <= '0;
         acc    <= '0;
         cr     <= '0;
         j      <= '0;
         r      <= '0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  in_reg <= in_data;
                  acc    <= '0;
                  cr     <= '0;
                  j      <= '0;
                  r      <= '0;
                  ovf    <= 1'b0;
               end
            end
            S_CARRY: begin
               acc[j*LIMB_W +: LIMB_W] <= s[LIMB_W-1:0];
               cr <= cr_nxt;
               j  <= j + 1'b1;
               r  <= '0;
               if (j == J_LAST && top != '0) ovf <= 1'b1;
            end
            S_RED: begin
               // Only V < 8p reduces fully with the 4p/2p/p sequence.
               if (r == 2'd0 && acc >= K8) ovf <= 1'b1;
               if (acc >= k_sel) acc <= acc - k_sel;
               r <= r + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign out_data  = acc;
   assign out_ovf   = ovf;
   assign dbg_state = state;

endmodule

// File: tb/tb_redundant_to_fp.sv
// Directed-vector bench for redundant_to_fp: a driver pushes expected results into a
// queue, and a negedge monitor pops and compares them when the DUT presents an output.
module tb_redundant_to_fp;

   localparam logic [271:0] P = {16'b0, 256'h2523648240000001ba344d80000000086121000000000013a700000000000013};

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [303:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [271:0] out_data;
   logic         out_ovf;
   logic [1:0]   dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   redundant_to_fp dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .dbg_state (dbg_state)
   );

   logic [272:0] exp_q[$];
   int           exp_cyc_q[$];
   int           n_checks = 0;
   int           n_errors = 0;

   task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Term i occupies [76i+75:76i]; carries are subtracted from v so the packed value equals v.
   function automatic logic [303:0] enc(input logic [271:0] v, input logic [7:0] c0,
                                        input logic [7:0] c1, input logic [7:0] c2,
                                        input logic [7:0] c3);
      logic [271:0] t;
      logic [303:0] d;
      t = v - ({264'b0, c0} << 68) - ({264'b0, c1} << 136) - ({264'b0, c2} << 204);
      d[67:0]    = t[67:0];
      d[75:68]   = c0;
      d[143:76]  = t[135:68];
      d[151:144] = c1;
      d[219:152] = t[203:136];
      d[227:220] = c2;
      d[295:228] = t[271:204];
      d[303:296] = c3;
      return d;
   endfunction

   // Monitor
   logic prev_valid = 1'b0;
   logic chk_ready_next = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_valid     = 1'b0;
         chk_ready_next = 1'b0;
      end else begin
         if (chk_ready_next) begin
            check("in_ready_after_handshake", 272'(in_ready), 272'd1);
            chk_ready_next = 1'b0;
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_out: out_valid=1 with no pending result at cycle %0d", cyc);
            end else begin
               check("in_ready_low_while_busy", 272'(in_ready), 272'd0);
               if (!prev_valid)
                  check("latency", 272'(cyc - exp_cyc_q[0]), 272'd8);
               check("out_ovf", 272'(out_ovf), 272'(exp_q[0][272]));
               if (!exp_q[0][272])
                  check("out_data", out_data, exp_q[0][271:0]);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  void'(exp_cyc_q.pop_front());
                  chk_ready_next = 1'b1;
               end
            end
         end
         prev_valid = out_valid;
      end
   end

   // Driver
   task automatic send(input logic [303:0] d, input logic [271:0] e, input logic e_ovf,
                       input bit push);
      bit got = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: in_ready stayed low for 100 cycles");
         return;
      end
      in_valid = 1'b1;
      in_data  = d;
      if (push) begin
         exp_q.push_back({e_ovf, e});
         exp_cyc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 304; i++) in_data[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
         exp_q.delete();
         exp_cyc_q.delete();
      end
      #1;
   endtask

   initial begin
      logic [303:0] d;
      bit           seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready",  272'(in_ready),  272'd1);
      check("reset_out_valid", 272'(out_valid), 272'd0);
      check("reset_out_data",  out_data,        272'd0);
      check("reset_out_ovf",   272'(out_ovf),   272'd0);
      check("reset_state",     272'(dbg_state), 272'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      send(enc(272'd0, 8'h00, 8'h00, 8'h00, 8'h00), 272'd0, 1'b0, 1);
      drain();

      d = '0;
      d[67:0]  = 68'hF_FFFF_FFFF_FFFF_FFFF;
      d[75:68] = 8'h01;
      send(d, 272'h1F_FFFF_FFFF_FFFF_FFFF, 1'b0, 1);

      send(enc(P * 272'd7 + 272'd5, 8'h03, 8'hFF, 8'h7F, 8'h00), 272'd5, 1'b0, 1);
      send(enc(P, 8'h01, 8'h02, 8'h03, 8'h00), 272'd0, 1'b0, 1);
      send(enc(P - 272'd1, 8'h00, 8'h00, 8'h00, 8'h00), P - 272'd1, 1'b0, 1);
      send(enc(P * 272'd8 - 272'd1, 8'h11, 8'h22, 8'h33, 8'h00), P - 272'd1, 1'b0, 1);
      send(enc(P * 272'd3 + 272'd2, 8'h05, 8'h00, 8'h09, 8'h00), 272'd2, 1'b0, 1);
      send(enc(P * 272'd4, 8'h00, 8'h80, 8'h00, 8'h00), 272'd0, 1'b0, 1);
      send(enc(P * 272'd8, 8'h00, 8'h00, 8'h00, 8'h00), 272'd0, 1'b1, 1);
      send(enc(272'd0, 8'h00, 8'h00, 8'h00, 8'h01), 272'd0, 1'b1, 1);
      send(enc({272{1'b1}}, 8'h00, 8'h00, 8'h00, 8'h00), 272'd0, 1'b1, 1);
      drain();

      // Backpressure: out_ready low for 5 cycles once the result appears.
      out_ready = 1'b0;
      send(enc(P * 272'd2 + 272'd7, 8'h01, 8'h01, 8'h01, 8'h00), 272'd7, 1'b0, 1);
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         if (out_valid) begin
            seen = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL backpressure_wait: out_valid never rose");
      end
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      drain();

      // Abort a conversion mid-CARRY; no output may appear.
      send(enc(272'd12345, 8'h01, 8'h00, 8'h00, 8'h00), 272'd0, 1'b0, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_in_ready",  272'(in_ready),  272'd1);
      check("abort_out_valid", 272'(out_valid), 272'd0);
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      send(enc(272'd3, 8'h00, 8'h00, 8'h00, 8'h00), 272'd3, 1'b0, 1);
      drain();
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
